// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control unit for a 32-bit MIPS-subset datapath.
// Defining MC_CTRL_JAL_EN adds jal/jr support and widens reg_dst to 2 bits.
module mc_control_fsm #(
    parameter bit RESET_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       flag_z,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [4:0] alufn,
    output logic       sgnext,
    output logic       reg_write,
`ifdef MC_CTRL_JAL_EN
    output logic [1:0] reg_dst,
`else
    output logic       reg_dst,
`endif
    output logic       mem_to_reg,
    output logic       illegal,
    output logic       halted
);
`ifdef MC_CTRL_JAL_EN
    localparam int RDW = 2;
`else
    localparam int RDW = 1;
`endif
    localparam logic [4:0] FN_ADD  = 5'b00001;
    localparam logic [4:0] FN_SUB  = 5'b10001;
    localparam logic [4:0] FN_AND  = 5'b00000;
    localparam logic [4:0] FN_OR   = 5'b00100;
    localparam logic [4:0] FN_XOR  = 5'b01000;
    localparam logic [4:0] FN_NOR  = 5'b01100;
    localparam logic [4:0] FN_SLL  = 5'b00010;
    localparam logic [4:0] FN_SRL  = 5'b01010;
    localparam logic [4:0] FN_SRA  = 5'b01110;
    localparam logic [4:0] FN_SLT  = 5'b10011;
    localparam logic [4:0] FN_SLTU = 5'b10111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] F_SLL    = 6'b000000;
    localparam logic [5:0] F_SRL    = 6'b000010;
    localparam logic [5:0] F_SRA    = 6'b000011;
`ifdef MC_CTRL_JAL_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] F_JR     = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC_R, WB_R,
        EXEC_I, WB_I, BRANCH, JUMP, ILLEGAL, HALT, JAL, JR
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_q;
    logic [4:0] r_fn, i_fn;
    logic       r_ok;

    // R-type ALU function; r_ok marks functs that run through EXEC_R
    always_comb begin
        r_ok = 1'b1;
        case (funct)
            6'b100000, 6'b100001: r_fn = FN_ADD;
            6'b100010, 6'b100011: r_fn = FN_SUB;
            6'b100100:            r_fn = FN_AND;
            6'b100101:            r_fn = FN_OR;
            6'b100110:            r_fn = FN_XOR;
            6'b100111:            r_fn = FN_NOR;
            6'b101010:            r_fn = FN_SLT;
            6'b101011:            r_fn = FN_SLTU;
            F_SLL:                r_fn = FN_SLL;
            F_SRL:                r_fn = FN_SRL;
            F_SRA:                r_fn = FN_SRA;
            default: begin
                r_fn = FN_ADD;
                r_ok = 1'b0;
            end
        endcase
    end

    // I-type ALU function, indexed by the low opcode bits of the 001xxx group
    always_comb begin
        case (op[2:0])
            3'd0, 3'd1: i_fn = FN_ADD;
            3'd2:       i_fn = FN_SLT;
            3'd3:       i_fn = FN_SLTU;
            3'd4:       i_fn = FN_AND;
            3'd5:       i_fn = FN_OR;
            3'd6:       i_fn = FN_XOR;
            default:    i_fn = FN_SLL;
        endcase
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) state_d = MEMADDR;
                else if (op == OP_RTYPE && r_ok) state_d = EXEC_R;
                else if (op[5:3] == 3'b001) state_d = EXEC_I;
                else if (op == OP_BEQ || op == OP_BNE) state_d = BRANCH;
                else if (op == OP_J) state_d = JUMP;
`ifdef MC_CTRL_JAL_EN
                else if (op == OP_JAL) state_d = JAL;
                else if (op == OP_RTYPE && funct == F_JR) state_d = JR;
`endif
                else state_d = ILLEGAL;
            end
            MEMADDR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXEC_R:  state_d = WB_R;
            EXEC_I:  state_d = WB_I;
            ILLEGAL: state_d = RESET_ILLEGAL ? HALT : FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // State register and sticky illegal flag, set on entry to ILLEGAL
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == ILLEGAL);
        end
    end

    // Control word; reset forces the idle word so a pending request drops immediately
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alufn      = FN_ADD;
        sgnext     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = '0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                sgnext    = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = (funct == F_SLL || funct == F_SRL || funct == F_SRA) ? 2'b10 : 2'b01;
                alufn     = r_fn;
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = RDW'(1);
            end
            EXEC_I: begin
                alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
                alu_src_b = 2'b10;
                alufn     = i_fn;
                sgnext    = ~op[2];
            end
            WB_I: reg_write = 1'b1;
            MEMADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                sgnext    = 1'b1;
            end
            MEMRD: mem_req = 1'b1;
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 2'b01;
                alufn     = FN_SUB;
                pc_src    = 2'b01;
                pc_write  = (op == OP_BNE) ? ~flag_z : flag_z;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            HALT: halted = 1'b1;
`ifdef MC_CTRL_JAL_EN
            JAL: begin
                pc_write  = 1'b1;
                pc_src    = 2'b10;
                reg_write = 1'b1;
                reg_dst   = RDW'(2);
            end
            JR: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alufn     = FN_OR;
            end
`endif
            default: ;
        endcase
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alufn      = FN_ADD;
            sgnext     = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = '0;
            mem_to_reg = 1'b0;
            halted     = 1'b0;
        end
    end

    assign illegal = illegal_q;

endmodule
